aes_round_ctrl: RTL and testbench
=================================

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter NR, default 10, number of AES rounds (10 = AES-128; legal range 2..14).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  plaintext block offered.
REQ-005 in_ready  output  1  controller can accept a block.
REQ-006 in_block  input  128  plaintext, FIPS-197 byte order, byte 0 = bits [127:120].
REQ-007 abort  input  1  synchronous cancel of any operation in progress.
REQ-008 rk_idx  output  4  round-key index requested from the external key schedule.
REQ-009 rk_data  input  128  round key for rk_idx, valid combinationally in the same cycle.
REQ-010 dp_state  output  128  state presented to the external round datapath (sub_bytes, shift_rows, mix_column, add_round_key).
REQ-011 dp_last  output  1  final round; datapath bypasses mix_column.
REQ-012 dp_result  input  128  combinational round result, returned in the same cycle.
REQ-013 out_valid  output  1  ciphertext available.
REQ-014 out_ready  input  1  consumer accepts the ciphertext.
REQ-015 out_block  output  128  ciphertext, same byte order as in_block.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, ROUND, DONE.
REQ-018 IDLE: in_ready = ~abort; rk_idx = 0.
REQ-019 Acceptance occurs on a clock edge where in_valid & in_ready. At that edge:
- state register <= in_block ^ rk_data (initial AddRoundKey);
- round counter <= 1;
- FSM -> ROUND.
REQ-020 ROUND: per cycle,
- rk_idx = round;
- dp_state = state register;
- dp_last = (round == NR);
- on the edge: state register <= dp_result, round counter increments.
REQ-021 ROUND with round == NR: the edge SHALL move the FSM to DONE after capturing dp_result.
REQ-022 DONE: out_valid = 1 and out_block = state register; both SHALL be held stable until the handshake.
REQ-023 DONE with out_ready = 1: the edge SHALL move the FSM to IDLE.
REQ-024 Latency: out_valid rises NR+1 cycles after the acceptance edge; one cycle per round; no pipelining.
REQ-025 in_ready SHALL be 0 in ROUND and DONE. in_valid during those states SHALL be ignored and not queued.
REQ-026 abort = 1 in any state SHALL force IDLE at the next edge and discard the block.
- abort beats out_ready in DONE.
- abort beats acceptance in IDLE.
REQ-027 The round counter SHALL be 4 bits wide and SHALL never exceed NR.
REQ-028 When not in ROUND, dp_state and dp_last SHALL be 0.
REQ-029 When not in DONE, out_valid SHALL be 0 and out_block SHALL be 0.

Reset
REQ-030 rst SHALL immediately force the following, independent of clk and including mid-operation: FSM = IDLE, round counter = 0, state register = 0, out_valid = 0, busy = 0.
REQ-031 in_ready SHALL be 1 while rst is high with abort = 0.
REQ-032 The first acceptance SHALL be possible on the first edge after rst deasserts.

Structure
REQ-033 Shared package aes_pkg SHALL hold:
- NR_AES128 = 10;
- the 128-bit block typedef;
- the FSM state enum;
- the byte-order mapping to the 4x4 [row][col] state array used by the round datapath.
REQ-034 No sub-module: FSM, round counter and state register live in aes_round_ctrl. The round datapath and key schedule stay external.

Verification (bench models the datapath and key schedule per FIPS-197)
REQ-035 FIPS-197 App. B:
- key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734;
- required: out_block 3925841d02dc09fbdc118597196a0b32, exactly 11 cycles after acceptance;
- dp_last high only in round 10.
REQ-036 FIPS-197 C.1:
- key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff;
- required: out_block 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-037 Backpressure: out_ready low for 5 cycles in DONE -> out_valid and out_block stable; IDLE on the cycle after out_ready = 1.
REQ-038 Second in_valid during ROUND -> not accepted. The next acceptance occurs only after returning to IDLE, and result 1 is unaffected.
REQ-039 abort in round 4 -> IDLE next edge, no out_valid. A following block produces the correct ciphertext.
REQ-040 rst asserted in round 6 -> all outputs at reset values immediately. Back-to-back App. B blocks afterwards -> both correct.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg
// Shared definitions for the AES round controller and anything that talks to
// its external round datapath and key schedule.
//   NR_AES128      : number of rounds for AES-128
//   NR_MAX         : largest round count the 4-bit round counter must reach
//   block_t        : 128-bit block, byte 0 = bits [127:120]
//   aes_state_t    : 4x4 byte array indexed [row][col]
//   state_e        : controller FSM state encoding
//   to_state_array / from_state_array : block <-> [row][col] mapping
package aes_pkg;

    localparam int NR_AES128 = 10;
    localparam int NR_MAX    = 14;
    localparam int RK_IDX_W  = 4;

    typedef logic [127:0] block_t;

    // s[r][c] holds input byte (r + 4*c): bytes fill the array column by column.
    typedef logic [0:3][0:3][7:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic aes_state_t to_state_array(input block_t blk);
        aes_state_t s;
        s = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                s[r][c] = blk[127 - 8 * (r + 4 * c) -: 8];
            end
        end
        return s;
    endfunction

    function automatic block_t from_state_array(input aes_state_t s);
        block_t blk;
        blk = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                blk[127 - 8 * (r + 4 * c) -: 8] = s[r][c];
            end
        end
        return blk;
    endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl
// Iterative AES encryption sequencer: one round per clock, datapath and key
// schedule live outside this block and answer combinationally.
//   clk, rst         : clock, asynchronous active-high reset
//   in_valid/ready   : plaintext handshake, in_block carries the plaintext
//   abort            : synchronous cancel, returns to IDLE and drops the block
//   rk_idx, rk_data  : round-key request and the key returned for it
//   dp_state/last    : state fed to the round datapath, last = skip mix_column
//   dp_result        : round datapath output
//   out_valid/ready  : ciphertext handshake, out_block carries the ciphertext
//   busy             : controller is not idle
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a block; key 0 is requested for the initial XOR
// ROUND | one AES round per cycle, round counter runs 1..NR
// DONE  | ciphertext held on out_block until out_ready
import aes_pkg::*;

module aes_round_ctrl #(
    parameter int NR = NR_AES128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    input  logic         abort,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic [127:0] dp_state,
    output logic         dp_last,
    input  logic [127:0] dp_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy
);

    localparam logic [3:0] NR_L = 4'(NR);

    state_e       state_q, state_d;
    logic [3:0]   round_q, round_d;
    block_t       data_q,  data_d;

    logic         last_round;

    assign last_round = (round_q == NR_L);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            round_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        data_d    = data_q;
        in_ready  = 1'b0;
        rk_idx    = '0;
        dp_state  = '0;
        dp_last   = 1'b0;
        out_valid = 1'b0;
        out_block = '0;
        busy      = 1'b1;

        unique case (state_q)
            IDLE: begin
                busy     = 1'b0;
                in_ready = ~abort;
                if (in_valid && !abort) begin
                    data_d  = in_block ^ rk_data;
                    round_d = 4'd1;
                    state_d = ROUND;
                end
            end

            ROUND: begin
                rk_idx   = round_q;
                dp_state = data_q;
                dp_last  = last_round;
                if (abort) begin
                    data_d  = '0;
                    round_d = '0;
                    state_d = IDLE;
                end else begin
                    data_d = dp_result;
                    if (last_round) begin
                        // Counter is cleared rather than bumped so it never passes NR.
                        round_d = '0;
                        state_d = DONE;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end
            end

            DONE: begin
                out_valid = 1'b1;
                out_block = data_q;
                if (abort || out_ready) begin
                    data_d  = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                data_d  = '0;
                round_d = '0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl
// Directed bench for aes_round_ctrl. The round datapath and key schedule are
// modelled here per FIPS-197; ciphertext expectations are the published
// FIPS-197 vectors.
import aes_pkg::*;

module tb_aes_round_ctrl;

    localparam block_t KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam block_t PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam block_t CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam block_t KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam block_t PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam block_t CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic         abort;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic [127:0] dp_state;
    logic         dp_last;
    logic [127:0] dp_result;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic         busy;

    logic [7:0]   sbox   [256];
    block_t       rk_tab [16];

    int n_vec;
    int n_err;

    aes_round_ctrl #(.NR(NR_AES128)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .abort     (abort),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data),
        .dp_state  (dp_state),
        .dp_last   (dp_last),
        .dp_result (dp_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- FIPS-197 model of the external blocks ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                    ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic expand_key(input block_t key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 16; r++) rk_tab[r] = '0;
        for (int r = 0; r <= NR_AES128; r++) begin
            rk_tab[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
        end
    endtask

    function automatic block_t aes_round(input block_t s_in, input block_t k, input logic last);
        aes_state_t a, b;
        logic [7:0] c0, c1, c2, c3;
        a = to_state_array(s_in);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                a[r][c] = sbox[a[r][c]];
        b = a;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                b[r][c] = a[r][(c + r) % 4];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                c0 = b[0][c]; c1 = b[1][c]; c2 = b[2][c]; c3 = b[3][c];
                b[0][c] = xtime(c0) ^ xtime(c1) ^ c1 ^ c2 ^ c3;
                b[1][c] = c0 ^ xtime(c1) ^ xtime(c2) ^ c2 ^ c3;
                b[2][c] = c0 ^ c1 ^ xtime(c2) ^ xtime(c3) ^ c3;
                b[3][c] = xtime(c0) ^ c0 ^ c1 ^ c2 ^ xtime(c3);
            end
        end
        return from_state_array(b) ^ k;
    endfunction

    assign rk_data   = rk_tab[rk_idx];
    assign dp_result = aes_round(dp_state, rk_data, dp_last);

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at the falling edge of the cycle in which the block is offered.
    // Counts cycles from that cycle until out_valid is seen.
    task automatic run_to_done(input bit hold, output int cyc, output int lc, output int lr);
        cyc = 0;
        lc  = 0;
        lr  = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!hold) in_valid = 1'b0;
            if (dp_last) begin
                lc++;
                lr = int'(rk_idx);
            end
        end while (!out_valid && cyc < 40);
    endtask

    // Called at a falling edge in DONE; holds off the consumer for n cycles.
    task automatic drain(input int n, input block_t exp);
        for (int i = 0; i < n; i++) begin
            chk("bp_valid", 128'(out_valid), 128'd1);
            chk("bp_block", out_block, exp);
            @(negedge clk);
        end
        chk("hold_block", out_block, exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_busy", 128'(busy), 128'd0);
        chk("idle_out_valid", 128'(out_valid), 128'd0);
        chk("idle_out_block", out_block, 128'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc, lc, lr;
        bit seen;
        n_vec = 0;
        n_err = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_block  = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        build_sbox();
        expand_key(KEY_B);
        #1 rst = 1'b1;

        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_block", out_block, 128'd0);
        chk("rst_dp_state", dp_state, 128'd0);
        chk("rst_dp_last", 128'(dp_last), 128'd0);
        chk("rst_rk_idx", 128'(rk_idx), 128'd0);
        abort = 1'b1;
        #1 chk("rst_abort_in_ready", 128'(in_ready), 128'd0);
        abort = 1'b0;

        // App. B, offered on the very first edge after reset release.
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b1;
        in_block = PT_B;
        #1 chk("b_in_ready", 128'(in_ready), 128'd1);
        run_to_done(1'b0, cyc, lc, lr);
        chk("b_latency", 128'(cyc), 128'd11);
        chk("b_last_count", 128'(lc), 128'd1);
        chk("b_last_round", 128'(lr), 128'd10);
        chk("b_out_block", out_block, CT_B);
        drain(5, CT_B);

        // C.1
        expand_key(KEY_C);
        in_valid = 1'b1;
        in_block = PT_C;
        run_to_done(1'b0, cyc, lc, lr);
        chk("c_latency", 128'(cyc), 128'd11);
        chk("c_out_block", out_block, CT_C);
        drain(0, CT_C);

        // Abort wins over acceptance in IDLE.
        in_valid = 1'b1;
        in_block = PT_C;
        abort    = 1'b1;
        #1 chk("abort_idle_in_ready", 128'(in_ready), 128'd0);
        @(negedge clk);
        chk("abort_idle_busy", 128'(busy), 128'd0);
        abort    = 1'b0;
        in_valid = 1'b0;

        // Second offer during ROUND is ignored, then taken once IDLE.
        expand_key(KEY_B);
        @(negedge clk);
        in_valid = 1'b1;
        in_block = PT_B;
        run_to_done(1'b1, cyc, lc, lr);
        chk("ovl_latency", 128'(cyc), 128'd11);
        chk("ovl_out_block", out_block, CT_B);
        chk("ovl_done_in_ready", 128'(in_ready), 128'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("ovl_idle_busy", 128'(busy), 128'd0);
        chk("ovl_idle_in_ready", 128'(in_ready), 128'd1);
        run_to_done(1'b0, cyc, lc, lr);
        chk("ovl2_latency", 128'(cyc), 128'd11);
        chk("ovl2_out_block", out_block, CT_B);
        drain(0, CT_B);

        // Abort in round 4, then a clean C.1 block.
        in_valid = 1'b1;
        in_block = PT_B;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        chk("abort_rk_idx", 128'(rk_idx), 128'd4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 128'(busy), 128'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_out_valid", 128'(seen), 128'd0);
        expand_key(KEY_C);
        in_valid = 1'b1;
        in_block = PT_C;
        run_to_done(1'b0, cyc, lc, lr);
        chk("post_abort_out_block", out_block, CT_C);

        // Abort beats out_ready in DONE: block is dropped either way, FSM idles.
        abort     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        out_ready = 1'b0;
        chk("abort_done_busy", 128'(busy), 128'd0);
        chk("abort_done_out_valid", 128'(out_valid), 128'd0);

        // Reset in round 6 takes effect without a clock edge.
        expand_key(KEY_B);
        in_valid = 1'b1;
        in_block = PT_B;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        chk("r6_rk_idx", 128'(rk_idx), 128'd6);
        rst = 1'b1;
        #1;
        chk("r6_busy", 128'(busy), 128'd0);
        chk("r6_dp_state", dp_state, 128'd0);
        chk("r6_dp_last", 128'(dp_last), 128'd0);
        chk("r6_rk_idx_rst", 128'(rk_idx), 128'd0);
        chk("r6_in_ready", 128'(in_ready), 128'd1);
        chk("r6_out_valid", 128'(out_valid), 128'd0);

        // Back-to-back App. B blocks after reset.
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b1;
        in_block = PT_B;
        run_to_done(1'b1, cyc, lc, lr);
        chk("bb1_latency", 128'(cyc), 128'd11);
        chk("bb1_out_block", out_block, CT_B);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bb_idle_in_ready", 128'(in_ready), 128'd1);
        run_to_done(1'b0, cyc, lc, lr);
        chk("bb2_latency", 128'(cyc), 128'd11);
        chk("bb2_out_block", out_block, CT_B);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bb_end_busy", 128'(busy), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
